// File: rtl/vga_timing_pkg.sv
// Raster timing constants for the 640x480 @ 60 Hz display path, shared by the
// timing generator and the per-pixel region detectors.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus sync/blank/strobe decode. Every output is a register
// decoded from the next-state coordinates, so all outputs line up with DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE_CFG = H_ACTIVE,
  parameter int unsigned H_FP_CFG     = H_FP,
  parameter int unsigned H_SYNC_CFG   = H_SYNC,
  parameter int unsigned H_BP_CFG     = H_BP,
  parameter int unsigned V_ACTIVE_CFG = V_ACTIVE,
  parameter int unsigned V_FP_CFG     = V_FP,
  parameter int unsigned V_SYNC_CFG   = V_SYNC,
  parameter int unsigned V_BP_CFG     = V_BP
) (
  input  logic             pixel_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             hs,
  output logic             vs,
  output logic             active_nblank,
  output logic             sync,
  output logic             frame_start,
  output logic             vblank_start,
  output logic [7:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE_CFG);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG + H_BP_CFG - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE_CFG + H_FP_CFG);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE_CFG);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG + V_BP_CFG - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE_CFG + V_FP_CFG);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG);

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             active_nxt;
  logic             frame_start_nxt;
  logic             vblank_start_nxt;

  assign sync = 1'b0;

  // Next raster position: X wraps every line, Y advances only on the X wrap.
  always_comb begin
    x_nxt = DrawX;
    y_nxt = DrawY;
    if (DrawX == H_LAST) begin
      x_nxt = '0;
      if (DrawY == V_LAST) begin
        y_nxt = '0;
      end else begin
        y_nxt = DrawY + 10'd1;
      end
    end else begin
      x_nxt = DrawX + 10'd1;
      y_nxt = DrawY;
    end
  end

  // Decode from the next position so the registered flags match the registered coordinates.
  always_comb begin
    hs_nxt           = ~in_window(x_nxt, HS_START, HS_END);
    vs_nxt           = ~in_window(y_nxt, VS_START, VS_END);
    active_nxt       = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    frame_start_nxt  = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    vblank_start_nxt = (x_nxt == 10'd0) && (y_nxt == V_ACT);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      DrawX         <= '0;
      DrawY         <= '0;
      hs            <= 1'b1;
      vs            <= 1'b1;
      active_nblank <= 1'b0;
      frame_start   <= 1'b0;
      vblank_start  <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      DrawX         <= x_nxt;
      DrawY         <= y_nxt;
      hs            <= hs_nxt;
      vs            <= vs_nxt;
      active_nblank <= active_nxt;
      frame_start   <= frame_start_nxt;
      vblank_start  <= vblank_start_nxt;
      if (frame_start_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size instance checks line timing and mid-line reset,
// a shrunken-raster instance covers vsync, strobes and the 256-frame counter wrap.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic       vbs;
    logic [7:0] fc;
  } obs_t;

  localparam int NCYC = 52000;
  localparam int RAND_RST_END = 3000;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_act, a_sync, a_fs, a_vbs;
  logic       b_hs, b_vs, b_act, b_sync, b_fs, b_vbs;
  logic [7:0] a_fc, b_fc;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .pixel_clk(clk), .reset(rst_a), .DrawX(a_x), .DrawY(a_y), .hs(a_hs), .vs(a_vs),
    .active_nblank(a_act), .sync(a_sync), .frame_start(a_fs), .vblank_start(a_vbs),
    .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE_CFG(8), .H_FP_CFG(2), .H_SYNC_CFG(3), .H_BP_CFG(3),
    .V_ACTIVE_CFG(6), .V_FP_CFG(1), .V_SYNC_CFG(2), .V_BP_CFG(2)
  ) dut_b (
    .pixel_clk(clk), .reset(rst_b), .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs),
    .active_nblank(b_act), .sync(b_sync), .frame_start(b_fs), .vblank_start(b_vbs),
    .frame_cnt(b_fc)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t qa[$];
  obs_t qb[$];
  bit   done = 1'b0;
  int   b_fs_exp = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference raster: position advances modulo the line/frame size; flags follow from the window rules.
  function automatic obs_t model_step(obs_t cur, bit rst, int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb);
    obs_t n;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int x;
    int y;
    n = '0;
    if (rst) begin
      n.hs = 1'b1;
      n.vs = 1'b1;
    end else begin
      x = (int'(cur.x) + 1) % ht;
      y = int'(cur.y);
      if (x == 0) y = (y + 1) % vt;
      n.x   = 10'(x);
      n.y   = 10'(y);
      n.hs  = !(x >= ha + hf && x < ha + hf + hsw);
      n.vs  = !(y >= va + vf && y < va + vf + vsw);
      n.act = (x < ha) && (y < va);
      n.fs  = (x == 0) && (y == 0);
      n.vbs = (x == 0) && (y == va);
      n.fc  = cur.fc + (n.fs ? 8'd1 : 8'd0);
    end
    return n;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t got, input obs_t exp);
    check({tag, ".DrawX"}, int'(got.x), int'(exp.x));
    check({tag, ".DrawY"}, int'(got.y), int'(exp.y));
    check({tag, ".hs"}, int'(got.hs), int'(exp.hs));
    check({tag, ".vs"}, int'(got.vs), int'(exp.vs));
    check({tag, ".active_nblank"}, int'(got.act), int'(exp.act));
    check({tag, ".frame_start"}, int'(got.fs), int'(exp.fs));
    check({tag, ".vblank_start"}, int'(got.vbs), int'(exp.vbs));
    check({tag, ".frame_cnt"}, int'(got.fc), int'(exp.fc));
  endtask

  // Monitor-side aggregate observations.
  int  a_act_l2 = 0;
  int  a_hsl_l2 = 0;
  int  b_fs_obs = 0;
  int  b_floor  = 0;
  bit  b_clean  = 1'b0;
  bit  b_wrap   = 1'b0;
  logic [7:0] b_prev_fc = 8'd0;

  initial begin : monitor
    obs_t ga, gb, ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      ga = '{a_x, a_y, a_hs, a_vs, a_act, a_fs, a_vbs, a_fc};
      gb = '{b_x, b_y, b_hs, b_vs, b_act, b_fs, b_vbs, b_fc};
      if (qa.size() == 0 || qb.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        cmp_obs("A", ga, ea);
        cmp_obs("B", gb, eb);
        check("A.sync", int'(a_sync), 0);
        check("B.sync", int'(b_sync), 0);
      end
      if (!rst_a && a_y == 10'd2) begin
        if (a_act) a_act_l2++;
        if (!a_hs) a_hsl_l2++;
      end
      if (rst_b) b_clean = 1'b0;
      if (b_act && b_y >= 10'd4 && b_y < 10'd6) b_floor++;
      if (b_fs) begin
        b_fs_obs++;
        if (b_fc == 8'd0 && b_prev_fc == 8'd255) b_wrap = 1'b1;
        if (b_clean) check("B.floor_per_frame", b_floor, 16);
        b_floor = 0;
        b_clean = !rst_b;
      end
      b_prev_fc = b_fc;
    end
  end

  initial begin : driver
    obs_t ma, mb;
    bit   ra, rb, a_mid_done;
    int   rb_hold;
    ma = '0; ma.hs = 1'b1; ma.vs = 1'b1;
    mb = ma;
    a_mid_done = 1'b0;
    rb_hold = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      ra = (cyc < 5);
      if (!ra && !a_mid_done && ma.x == 10'd300 && ma.y == 10'd1) begin
        ra = 1'b1;
        a_mid_done = 1'b1;
      end
      if (cyc < 5) begin
        rb = 1'b1;
      end else if (rb_hold > 0) begin
        rb = 1'b1;
        rb_hold--;
      end else if (cyc < RAND_RST_END && $urandom_range(0, 199) == 0) begin
        rb = 1'b1;
        rb_hold = $urandom_range(0, 2);
      end else begin
        rb = 1'b0;
      end
      rst_a = ra;
      rst_b = rb;
      ma = model_step(ma, ra, 640, 16, 96, 48, 480, 10, 2, 33);
      mb = model_step(mb, rb, 8, 2, 3, 3, 6, 1, 2, 2);
      if (mb.fs) b_fs_exp++;
      qa.push_back(ma);
      qb.push_back(mb);
      @(negedge clk);
    end
    done = 1'b1;
    @(posedge clk);
    #2;
    check("A.reset_mid_line_seen", int'(a_mid_done), 1);
    check("A.active_cycles_line2", a_act_l2, 640);
    check("A.hs_low_cycles_line2", a_hsl_l2, 96);
    check("B.frame_start_count", b_fs_obs, b_fs_exp);
    check("B.frame_cnt_wrap_seen", int'(b_wrap), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
